// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline constants: default widths, the canonical
//                NOP encoding and the RV32 register-index field positions.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default datapath widths
    localparam int XLEN_DEF      = 32;
    localparam int REG_IDX_W_DEF = 5;

    // addi x0, x0, 0
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // Register-index field positions inside an instruction word
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RD_LSB  = 7;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/ifid_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ifid_fifo
//  Description : Generic DEPTH x W circular queue with push, pop and a
//                synchronous clear. State advances on the falling clock
//                edge so it lines up with the rest of the pipeline registers.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk    in   pipeline clock (state updates on falling edge)
//    rst    in   synchronous active-high reset
//    clear  in   synchronous discard of all entries (same effect as rst)
//    push   in   write wdata at the tail (ignored when full or clearing)
//    pop    in   drop the head entry   (ignored when empty or clearing)
//    wdata  in   W-bit entry to write
//    rdata  out  W-bit head entry (contents undefined while empty)
//    count  out  number of held entries, 0..DEPTH
//    full   out  count == DEPTH
//    empty  out  count == 0
// ============================================================================
module ifid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Guarded locally as well so the queue stays consistent even if a
    // caller drives push into a full queue or pop from an empty one.
    assign w_do_push = push & ~full  & ~clear;
    assign w_do_pop  = pop  & ~empty & ~clear;

    assign full  = (r_count == c_depth);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign rdata = r_mem[r_rp];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(negedge clk) begin
        if (rst || clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wp <= r_wp + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: an entry is only visible once it has been
    // written and counted.
    always_ff @(negedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= wdata;
        end
    end

endmodule : ifid_fifo
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_buffer
//  Description : IF->ID instruction buffer. Holds fetched {inst, pc} pairs
//                in an in-order queue, presents the head with its decoded
//                rs1/rs2/rd indices, and decouples fetch from decode with a
//                valid/ready handshake on both sides. flush discards all
//                held and incoming instructions on a redirect.
//  Revision    : 1.0 - initial release
//
//  Configuration macro
//    IFID_BUBBLE_NOP_EN  defined   : empty-queue inst_out = 32'h0000_0013
//                        undefined : empty-queue inst_out = 0
//
//  Ports
//    clk        in   pipeline clock; state updates on the falling edge
//    rst_ifid   in   synchronous active-high reset (dominates flush)
//    flush      in   drop all held entries and the incoming instruction
//    in_valid   in   fetch presents inst_in / pc_in
//    in_ready   out  buffer has room (from registered fill level only)
//    inst_in    in   fetched instruction
//    pc_in      in   PC of inst_in
//    out_valid  out  head entry valid
//    out_ready  in   decode consumes the head this edge
//    inst_out   out  head instruction, or bubble when empty
//    pc_out     out  head PC, or 0 when empty
//    reg1       out  rs1 field of inst_out
//    reg2       out  rs2 field of inst_out
//    dest       out  rd  field of inst_out
// ============================================================================
module if_id_buffer
    import pipe_pkg::*;
#(
    parameter int XLEN      = XLEN_DEF,
    parameter int DEPTH     = 2,
    parameter int REG_IDX_W = REG_IDX_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_ifid,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      inst_in,
    input  logic [XLEN-1:0]      pc_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      inst_out,
    output logic [XLEN-1:0]      pc_out,
    output logic [REG_IDX_W-1:0] reg1,
    output logic [REG_IDX_W-1:0] reg2,
    output logic [REG_IDX_W-1:0] dest
);

    localparam int ENTRY_W = 2 * XLEN;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] c_depth_cnt = CNT_W'(DEPTH);

`ifdef IFID_BUBBLE_NOP_EN
    localparam logic [XLEN-1:0] c_bubble = XLEN'(INST_NOP);
`else
    localparam logic [XLEN-1:0] c_bubble = '0;
`endif

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("if_id_buffer: DEPTH must be a power of two and at least 2");
    end

    if (XLEN < (RS2_LSB + REG_IDX_W)) begin : g_bad_xlen
        $error("if_id_buffer: XLEN too narrow for the register index fields");
    end

    // ------------------------------------------------------------------
    // Handshake and queue
    // ------------------------------------------------------------------
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;

    // in_ready depends only on the registered fill level: a pop on this
    // edge does not make room until the next one, which keeps out_ready
    // off the path to in_ready.
    assign in_ready  = ~w_full;
    assign out_valid = ~w_empty;

    // flush suppresses both sides so nothing is written or credited on
    // the redirect edge; the queue clear itself happens inside the FIFO.
    assign w_push = in_valid  & in_ready  & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    ifid_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst_ifid),
        .clear (flush),
        .push  (w_push),
        .pop   (w_pop),
        .wdata ({inst_in, pc_in}),
        .rdata (w_head),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // ------------------------------------------------------------------
    // Output muxing: the bubble keeps inst_out/pc_out defined while empty
    // (stale storage is never exposed).
    // ------------------------------------------------------------------
    always_comb begin
        inst_out = c_bubble;
        pc_out   = '0;
        if (out_valid) begin
            inst_out = w_head[ENTRY_W-1:XLEN];
            pc_out   = w_head[XLEN-1:0];
        end
    end

    // Field slices follow inst_out, so a bubble yields the bubble's fields.
    assign reg1 = inst_out[RS1_LSB +: REG_IDX_W];
    assign reg2 = inst_out[RS2_LSB +: REG_IDX_W];
    assign dest = inst_out[RD_LSB  +: REG_IDX_W];

    // ------------------------------------------------------------------
    // Internal consistency of the queue's status outputs
    // ------------------------------------------------------------------
    a_count_bound: assert property (@(negedge clk) disable iff (rst_ifid)
        w_count <= c_depth_cnt);

    a_full_match: assert property (@(negedge clk) disable iff (rst_ifid)
        w_full == (w_count == c_depth_cnt));

    a_empty_match: assert property (@(negedge clk) disable iff (rst_ifid)
        w_empty == (w_count == '0));

endmodule : if_id_buffer
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_buffer
//  Description : Self-checking bench for if_id_buffer. Two instances
//                (DEPTH=2 and DEPTH=4) share one stimulus stream. Each
//                instance keeps a queue of expected {inst, pc} entries:
//                accepted pushes are appended, handshakes remove the head,
//                and reset/flush empty it. A per-instance monitor compares
//                the DUT outputs with the queue every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ent_t;

`ifdef IFID_BUBBLE_NOP_EN
    localparam logic [31:0] BUBBLE = 32'h0000_0013;
`else
    localparam logic [31:0] BUBBLE = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        rst_ifid;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] inst_in;
    logic [31:0] pc_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    // Inputs change 2 time units after the rising edge; the DUT acts on the
    // falling edge, 5 units after the rising edge.
    task automatic drive(input bit r, input bit f, input bit v,
                         input logic [31:0] i, input logic [31:0] p,
                         input bit o);
        @(posedge clk);
        #2;
        rst_ifid  = r;
        flush     = f;
        in_valid  = v;
        inst_in   = i;
        pc_in     = p;
        out_ready = o;
    endtask

    // ------------------------------------------------------------------
    // DUT instances, each with its own expected-entry queue and monitor
    // ------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int D = (k == 0) ? 2 : 4;

        logic        in_ready;
        logic        out_valid;
        logic [31:0] inst_out;
        logic [31:0] pc_out;
        logic [4:0]  reg1;
        logic [4:0]  reg2;
        logic [4:0]  dest;

        ent_t        sb[$];
        bit          armed = 1'b0;
        bit          do_pop;
        bit          do_push;
        logic [31:0] e_inst;
        logic [31:0] e_pc;

        if_id_buffer #(
            .XLEN      (32),
            .DEPTH     (D),
            .REG_IDX_W (5)
        ) u_dut (
            .clk       (clk),
            .rst_ifid  (rst_ifid),
            .flush     (flush),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .inst_in   (inst_in),
            .pc_in     (pc_in),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .inst_out  (inst_out),
            .pc_out    (pc_out),
            .reg1      (reg1),
            .reg2      (reg2),
            .dest      (dest)
        );

        always @(posedge clk) begin
            // +1: compare DUT state (settled since the last falling edge)
            #1;
            if (armed) begin
                chk($sformatf("d%0d out_valid", D), 32'(out_valid), 32'(sb.size() != 0));
                chk($sformatf("d%0d in_ready", D),  32'(in_ready),  32'(sb.size() != D));
                if (sb.size() != 0) begin
                    e_inst = sb[0].inst;
                    e_pc   = sb[0].pc;
                end else begin
                    e_inst = BUBBLE;
                    e_pc   = 32'h0;
                end
                chk($sformatf("d%0d inst_out", D), inst_out, e_inst);
                chk($sformatf("d%0d pc_out", D),   pc_out,   e_pc);
                chk($sformatf("d%0d reg1", D), 32'(reg1), 32'(e_inst[19:15]));
                chk($sformatf("d%0d reg2", D), 32'(reg2), 32'(e_inst[24:20]));
                chk($sformatf("d%0d dest", D), 32'(dest), 32'(e_inst[11:7]));
            end
            // +3: inputs for the coming falling edge are now stable
            #2;
            if (rst_ifid) begin
                armed = 1'b1;
            end
            if (rst_ifid || flush) begin
                sb.delete();
            end else if (armed) begin
                // Room and head are judged on the queue as it stood before
                // this edge: a same-edge pop never makes room for a push.
                do_pop  = (sb.size() != 0) && out_ready;
                do_push = in_valid && (sb.size() != D);
                if (do_pop) begin
                    sb.delete(0);
                end
                if (do_push) begin
                    sb.push_back(ent_t'{inst: inst_in, pc: pc_in});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int n;
        int guard;
        bit r;
        bit f;
        bit v;
        bit o;

        rst_ifid  = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inst_in   = '0;
        pc_in     = '0;

        // Reset, then idle
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Single instruction with decode ready
        drive(0, 0, 1, 32'h00A2_8293, 32'h100, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Decode stalled: three pushes, the third held by fetch
        drive(0, 0, 1, 32'h00B3_0313, 32'h200, 0);
        drive(0, 0, 1, 32'h00C3_8393, 32'h204, 0);
        drive(0, 0, 1, 32'h00D4_0413, 32'h208, 0);
        drive(0, 0, 1, 32'h00D4_0413, 32'h208, 0);
        // Full with both sides active: pop only
        drive(0, 0, 1, 32'h00D4_0413, 32'h208, 1);
        drive(0, 0, 1, 32'h00D4_0413, 32'h208, 0);
        drive(0, 0, 1, 32'h00D4_0413, 32'h208, 0);

        // Flush while full with an incoming instruction
        drive(0, 1, 1, 32'h00E4_8493, 32'h20C, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);
        drive(0, 0, 0, 32'h0, 32'h0, 1);

        // Mid-stream reset together with flush
        drive(0, 0, 1, 32'h0000_0001, 32'h300, 0);
        drive(0, 0, 1, 32'h0000_0002, 32'h304, 0);
        drive(0, 0, 1, 32'h0000_0003, 32'h308, 0);
        drive(1, 1, 1, 32'h0000_0004, 32'h30C, 1);

        // 0x11, 0x22, ... through the DEPTH=4 queue, wrapping its pointers
        n     = 0;
        guard = 0;
        while ((n < 10) && (guard < 200)) begin
            drive(0, 0, 1, 32'h11 * (n + 1), 32'h400 + 4 * n, 1'($urandom_range(0, 1)));
            guard++;
            if (g_dut[1].in_ready === 1'b1) begin
                n++;
            end
        end
        chk("d4 ordered pushes completed", 32'(n), 32'd10);
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 32'h0, 32'h0, 1);
        end

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 199) == 0);
            f = ($urandom_range(0, 29) == 0);
            v = ($urandom_range(0, 9) < 7);
            o = ($urandom_range(0, 9) < 6);
            drive(r, f, v, $urandom, $urandom, o);
        end
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 32'h0, 32'h0, 1);
        end

        @(posedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_id_buffer
`default_nettype wire

// File: doc/if_id_buffer.md
# if_id_buffer

Parametrised instruction register for the IF→ID boundary. It holds fetched instructions and their PCs in a small in-order queue and exposes the head entry with its decoded register indices (rs1, rs2, rd). A valid/ready handshake on both sides lets fetch keep running while decode stalls. A flush input discards all in-flight instructions on a redirect. It sits between the instruction-memory read port and the decode/register-file stage.

## Interface
- XLEN, 32: instruction and PC width
- DEPTH, 2: queue entries; power of two, ≥2
- REG_IDX_W, 5: register index width
- clk  in  1  pipeline clock; all state updates on the falling edge, as for every pipeline register in the design
- rst_ifid  in  1  reset, synchronous, active-high
- flush  in  1  discard all held and incoming instructions
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  buffer accepts this edge
- inst_in  in  XLEN  fetched instruction
- pc_in  in  XLEN  PC of inst_in
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head (low = stall)
- inst_out  out  XLEN  head instruction
- pc_out  out  XLEN  head PC
- reg1  out  REG_IDX_W  inst_out[19:15]
- reg2  out  REG_IDX_W  inst_out[24:20]
- dest  out  REG_IDX_W  inst_out[11:7]

## Operation
- Storage: circular array of DEPTH {inst, pc}; write pointer wp, read pointer rp, both log2(DEPTH) bits; count is $clog2(DEPTH+1) bits.
- in_ready = (count != DEPTH), from registered count only; no combinational path from out_ready.
- push = in_valid & in_ready & !flush; pop = out_valid & out_ready & !flush.
- push: entry[wp] ← {inst_in, pc_in}, wp+1 (wraps mod DEPTH). pop: rp+1 (wraps).
- count: +1 push only, −1 pop only, unchanged for both or neither. Push and pop in the same edge are legal at any fill level below full. When full, no push occurs even if pop.
- out_valid = (count != 0). inst_out/pc_out = entry[rp] when valid, otherwise the bubble value (see Configuration). pc_out bubble = 0.
- reg1/reg2/dest are combinational slices of inst_out, so the bubble value also determines them.
- flush: on that edge wp=rp=0, count=0. The incoming instruction is dropped and no pop is credited. Flush dominates push, pop and full.
- Reset: wp=rp=count=0. Storage contents are don't-care. After reset: out_valid=0, in_ready=1, inst_out=bubble, pc_out=0, reg1=reg2=dest=bubble fields. Reset asserted mid-stream discards all entries the same way flush does. Reset dominates flush.
- Held outputs stay stable while out_valid=1 and out_ready=0.

## Timing
- Latency: an instruction accepted at edge N appears on inst_out after edge N if the queue was empty; there is no combinational bypass.
- Throughput: 1 instruction per edge sustained while out_ready=1.
- in_ready reflects state after the previous edge. A pop does not free space until the following edge.
- After flush at edge N: out_valid=0 and in_ready=1 following edge N. The first new push is possible at edge N+1.

## Configuration
- IFID_BUBBLE_NOP_EN defined: bubble value on inst_out is the canonical NOP 32'h0000_0013 (addi x0,x0,0). Bubble fields are reg1=0, reg2=0, dest=0.
- Undefined: bubble value is all-zero, matching the existing reset behaviour of the instruction register. Downstream then qualifies everything with out_valid.

## Structure
- Shared package pipe_pkg holds XLEN default, REG_IDX_W default, INST_NOP constant, and field bit positions (RS1_LSB=15, RS2_LSB=20, RD_LSB=7).
- One sub-module, ifid_fifo: generic DEPTH×W queue with push/pop/clear, count, full and empty. if_id_buffer wraps it with the handshake, flush priority, bubble muxing and field slicing.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, inst_out=0 (or 0x00000013 with IFID_BUBBLE_NOP_EN), pc_out=0.
- Push 0x00A28293 @pc 0x100 with out_ready=1: next edge out_valid=1, reg1=5, reg2=10, dest=5. It pops on the following edge.
- out_ready=0 and push three instructions (DEPTH=2): first two accepted, in_ready=0 after the second, third held by fetch. Outputs are stable on the first entry.
- Full with out_ready=1 and in_valid=1: one pop and no push this edge. in_ready=1 next edge, count=1.
- Flush while count=2 with in_valid=1: next edge out_valid=0, count=0, and the incoming instruction is absent afterwards.
- rst_ifid and flush asserted together mid-stream with DEPTH=4: all pointers 0. The sequence 0x11,0x22,0x33,0x44 pushed afterwards pops in order, with wrap-around verified over 10 pushes.
